vga_pixel_renderer: RTL and testbench
=====================================

Name: vga_pixel_renderer

Overview:
- Downstream neighbour of the VGA memory address generator, in the same clock domain.
- Consumes its per-pixel selection (mem_select, tile/char address and offsets plus show_en), issues reads to the shared tile ROM and char ROM, and maps the 4-bit colour index through a fixed palette.
- Drives registered 8-bit RGB to the VGA pins.
- Owns the power-pellet blink timing, counted in frames.

Parameters:
- ROM_LAT, 1: read latency of both ROMs in cycles, range 1..3.
- BLINK_FRAMES, 10: frames per blink phase, range 1..255.
- PELLET_TILE, 5'd2: map tile code that blinks.

Ports:
- i_clk  in  1  system clock.
- i_rst  in  1  synchronous reset, active-high.
- i_show_en  in  1  pixel is inside display time.
- i_frame_start  in  1  single-cycle pulse at the start of each frame.
- i_mem_select  in  2  0=map tile, 1=pacman char, 2=ghost char, 3=none.
- i_address_map  in  5  map tile code.
- i_address_char  in  8  char glyph index.
- i_tile_offset  in  6  pixel within an 8x8 tile, row-major.
- i_char_offset  in  6  pixel within an 8x8 char, row-major.
- o_tile_rom_addr  out  11  {address_map, tile_offset}.
- i_tile_rom_data  in  4  colour index, valid ROM_LAT cycles after the address.
- o_char_rom_addr  out  14  {address_char, char_offset}.
- i_char_rom_data  in  4  colour index, valid ROM_LAT cycles after the address.
- o_vga_r  out  8  red.
- o_vga_g  out  8  green.
- o_vga_b  out  8  blue.
- o_show_en  out  1  i_show_en delayed to align with RGB.

Behaviour:
- Reset (i_rst high at a clock edge):
  - All pipeline registers, ROM address outputs, RGB, o_show_en, the frame counter and the blink phase clear to 0.
  - Reset mid-line discards in-flight pixels; the first valid pixel reaches the output ROM_LAT+2 cycles after the first post-reset show_en.
- Pipeline, one pixel per cycle, no stalls:
  - S0: register the inputs. Drive both ROM addresses every cycle regardless of select. Capture a kill flag = (select==0 && address_map==PELLET_TILE && blink_phase==1).
  - S1..S(ROM_LAT): a delay line carries show_en, select and kill.
  - SP (palette): pick tile data for select 0 and char data for select 1/2. Force index 0 if select==3, kill==1 or show_en==0. Look up the 24-bit palette.
  - Output register drives RGB and o_show_en.
  - Total latency from input to RGB/o_show_en is ROM_LAT+2 cycles. The ROM addresses are registered, so they lag the inputs by 1 cycle.
- Colour index 0 is always black (0,0,0). Index 0 in char data is rendered black; there is no transparency compositing.
- Blink logic:
  - An 8-bit frame_cnt increments on each i_frame_start.
  - When frame_cnt==BLINK_FRAMES-1 on a pulse, frame_cnt returns to 0 and blink_phase toggles in the same cycle.
  - blink_phase is sampled only at S0. A pulse coinciding with an active pixel affects pixels entering S0 from the next cycle on.
  - i_frame_start and i_show_en may be high together; both are honoured.
- No handshake: upstream is free-running and the ROMs are synchronous with fixed latency.
- Arithmetic: address concatenation only. frame_cnt wraps modulo BLINK_FRAMES.

Decomposition:
- Package pacman_render_pkg holds:
  - typedef mem_sel_e (SEL_MAP, SEL_PACMAN, SEL_GHOST, SEL_NONE);
  - widths TILE_ADDR_W=11, CHAR_ADDR_W=14, CIDX_W=4;
  - localparam PALETTE[16] of 24-bit RGB (0 black, 1 maze blue 2121FF, 2 pellet FFB8AE, 3 pacman yellow FFFF00, 4 ghost red FF0000, rest assigned there).
- One sub-module, render_delay_line: parameterised depth/width shift register used for the S1..S(ROM_LAT) stages.

Test Plan:
- Reset: hold i_rst 3 cycles with random inputs -> RGB, o_show_en and both ROM addresses are 0 throughout and on the cycle after release.
- Latency/map pixel, ROM_LAT=1: show_en=1, select=0, map=5'd1, tile_offset=6'd9, tile ROM model returns idx 1 -> o_tile_rom_addr=11'h049 one cycle later; RGB=2121FF with o_show_en=1 exactly 3 cycles after the input.
- Char select: select=1, char=8'h03, offset=6'd0, char ROM returns 3 -> o_char_rom_addr=14'h00C0; RGB=FFFF00 at +3. With select=3 the same inputs give 000000.
- Blanking: show_en=0 with select=0 and ROM idx 1 -> RGB=000000 and o_show_en=0 at +3.
- Blink, BLINK_FRAMES=2: pellet tile (map=2, ROM idx 2) each frame -> FFB8AE in frames 0-1, black in frames 2-3, FFB8AE in frame 4; pulse coincident with a pellet pixel leaves that pixel's colour unchanged.
- Throughput and ROM_LAT=3: a 640-pixel line of alternating select 0/1 -> 640 consecutive valid outputs with no gaps, starting at +5, in order.

Source files
------------

// File: rtl/pacman_render_pkg.sv
// Shared types, widths and the fixed colour palette for the pixel renderer.
// Imported by the renderer top and its pipeline helpers.
package pacman_render_pkg;

  typedef enum logic [1:0] {
    SEL_MAP    = 2'd0,
    SEL_PACMAN = 2'd1,
    SEL_GHOST  = 2'd2,
    SEL_NONE   = 2'd3
  } mem_sel_e;

  localparam int TILE_ADDR_W = 11;
  localparam int CHAR_ADDR_W = 14;
  localparam int CIDX_W      = 4;

  // Index 0 must stay black: it doubles as the blank/kill colour.
  localparam logic [23:0] PALETTE [16] = '{
    24'h000000,  // 0 black
    24'h2121FF,  // 1 maze blue
    24'hFFB8AE,  // 2 pellet
    24'hFFFF00,  // 3 pacman yellow
    24'hFF0000,  // 4 ghost red
    24'hFFB8FF,  // 5 pink ghost
    24'h00FFFF,  // 6 cyan ghost
    24'hFFB852,  // 7 orange ghost
    24'hFFFFFF,  // 8 white
    24'h2121DE,  // 9 frightened blue
    24'hDEDEFF,  // 10 ghost eyes
    24'h47B8FF,  // 11 light blue
    24'h00FF00,  // 12 green
    24'hFFB847,  // 13 tan
    24'hDE9751,  // 14 brown
    24'h808080   // 15 grey
  };

  typedef struct packed {
    logic     show_en;
    mem_sel_e sel;
    logic     kill;
  } stage_t;

endpackage

// File: rtl/render_delay_line.sv
// Fixed-depth shift register carrying per-pixel control alongside the ROM reads.
// Every stage clears on reset so in-flight pixels are dropped.
module render_delay_line #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data
);

  logic [DEPTH:0][WIDTH-1:0] tap;

  assign tap[0] = i_data;

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : gen_stage
      logic [WIDTH-1:0] stage_reg;

      always_ff @(posedge i_clk) begin
        if (i_rst) begin
          stage_reg <= '0;
        end else begin
          stage_reg <= tap[gi];
        end
      end

      assign tap[gi+1] = stage_reg;
    end
  endgenerate

  assign o_data = tap[DEPTH];

endmodule

// File: rtl/vga_pixel_renderer.sv
// Turns the per-pixel memory selection into ROM reads, palette lookup and
// registered RGB; also owns the power-pellet blink timing.
module vga_pixel_renderer
  import pacman_render_pkg::*;
#(
  parameter int          ROM_LAT      = 1,
  parameter int          BLINK_FRAMES = 10,
  parameter logic [4:0]  PELLET_TILE  = 5'd2
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_show_en,
  input  logic                   i_frame_start,
  input  logic [1:0]             i_mem_select,
  input  logic [4:0]             i_address_map,
  input  logic [7:0]             i_address_char,
  input  logic [5:0]             i_tile_offset,
  input  logic [5:0]             i_char_offset,
  output logic [TILE_ADDR_W-1:0] o_tile_rom_addr,
  input  logic [CIDX_W-1:0]      i_tile_rom_data,
  output logic [CHAR_ADDR_W-1:0] o_char_rom_addr,
  input  logic [CIDX_W-1:0]      i_char_rom_data,
  output logic [7:0]             o_vga_r,
  output logic [7:0]             o_vga_g,
  output logic [7:0]             o_vga_b,
  output logic                   o_show_en
);

  logic [TILE_ADDR_W-1:0] tile_addr_reg;
  logic [CHAR_ADDR_W-1:0] char_addr_reg;
  stage_t                 s0_reg;
  stage_t                 sp_stage;
  logic [7:0]             frame_cnt_reg;
  logic                   blink_phase_reg;
  logic [CIDX_W-1:0]      cidx_next;
  logic [23:0]            rgb_next;
  logic [23:0]            rgb_reg;
  logic                   show_out_reg;
  mem_sel_e               sel_in;

  assign sel_in = mem_sel_e'(i_mem_select);

  // Blink phase flips every BLINK_FRAMES frame pulses.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      frame_cnt_reg   <= '0;
      blink_phase_reg <= 1'b0;
    end else if (i_frame_start) begin
      if (frame_cnt_reg == 8'(BLINK_FRAMES - 1)) begin
        frame_cnt_reg   <= '0;
        blink_phase_reg <= ~blink_phase_reg;
      end else begin
        frame_cnt_reg <= frame_cnt_reg + 8'd1;
      end
    end
  end

  // S0: both ROMs are addressed every cycle; the select decides later which
  // result is used, which keeps the address path free of muxing.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      tile_addr_reg <= '0;
      char_addr_reg <= '0;
      s0_reg        <= '0;
    end else begin
      tile_addr_reg  <= {i_address_map, i_tile_offset};
      char_addr_reg  <= {i_address_char, i_char_offset};
      s0_reg.show_en <= i_show_en;
      s0_reg.sel     <= sel_in;
      s0_reg.kill    <= (sel_in == SEL_MAP) && (i_address_map == PELLET_TILE)
                        && blink_phase_reg;
    end
  end

  assign o_tile_rom_addr = tile_addr_reg;
  assign o_char_rom_addr = char_addr_reg;

  render_delay_line #(
    .DEPTH (ROM_LAT),
    .WIDTH ($bits(stage_t))
  ) u_delay_line (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_data (s0_reg),
    .o_data (sp_stage)
  );

  always_comb begin
    cidx_next = '0;
    case (sp_stage.sel)
      SEL_MAP:               cidx_next = i_tile_rom_data;
      SEL_PACMAN, SEL_GHOST: cidx_next = i_char_rom_data;
      default:               cidx_next = '0;
    endcase
    if (!sp_stage.show_en || sp_stage.kill) begin
      cidx_next = '0;
    end
    rgb_next = PALETTE[cidx_next];
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rgb_reg      <= '0;
      show_out_reg <= 1'b0;
    end else begin
      rgb_reg      <= rgb_next;
      show_out_reg <= sp_stage.show_en;
    end
  end

  assign o_vga_r   = rgb_reg[23:16];
  assign o_vga_g   = rgb_reg[15:8];
  assign o_vga_b   = rgb_reg[7:0];
  assign o_show_en = show_out_reg;

endmodule

// File: tb/tb_vga_pixel_renderer.sv
// Directed checks of the pixel renderer: reset, latency, select, blanking,
// pellet blink (ROM_LAT=1) and a full-line throughput run (ROM_LAT=3).
module tb_vga_pixel_renderer;

  logic        clk = 1'b0;
  logic        rst;
  logic        show_en;
  logic        frame_start;
  logic [1:0]  mem_select;
  logic [4:0]  address_map;
  logic [7:0]  address_char;
  logic [5:0]  tile_offset;
  logic [5:0]  char_offset;

  logic [10:0] d1_taddr, d3_taddr;
  logic [13:0] d1_caddr, d3_caddr;
  logic [3:0]  d1_tdata, d1_cdata, d3_tdata, d3_cdata;
  logic [7:0]  d1_r, d1_g, d1_b, d3_r, d3_g, d3_b;
  logic        d1_show, d3_show;

  logic [3:0]  t1_pipe, c1_pipe;
  logic [3:0]  t3_pipe [3];
  logic [3:0]  c3_pipe [3];

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  vga_pixel_renderer #(.ROM_LAT(1), .BLINK_FRAMES(2), .PELLET_TILE(5'd2)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_show_en(show_en), .i_frame_start(frame_start),
    .i_mem_select(mem_select), .i_address_map(address_map),
    .i_address_char(address_char), .i_tile_offset(tile_offset),
    .i_char_offset(char_offset), .o_tile_rom_addr(d1_taddr),
    .i_tile_rom_data(d1_tdata), .o_char_rom_addr(d1_caddr),
    .i_char_rom_data(d1_cdata), .o_vga_r(d1_r), .o_vga_g(d1_g), .o_vga_b(d1_b),
    .o_show_en(d1_show)
  );

  vga_pixel_renderer #(.ROM_LAT(3), .BLINK_FRAMES(2), .PELLET_TILE(5'd2)) dut3 (
    .i_clk(clk), .i_rst(rst), .i_show_en(show_en), .i_frame_start(frame_start),
    .i_mem_select(mem_select), .i_address_map(address_map),
    .i_address_char(address_char), .i_tile_offset(tile_offset),
    .i_char_offset(char_offset), .o_tile_rom_addr(d3_taddr),
    .i_tile_rom_data(d3_tdata), .o_char_rom_addr(d3_caddr),
    .i_char_rom_data(d3_cdata), .o_vga_r(d3_r), .o_vga_g(d3_g), .o_vga_b(d3_b),
    .o_show_en(d3_show)
  );

  // ROM models: colour index = low 4 bits of the tile/glyph code.
  always @(posedge clk) begin
    t1_pipe    <= d1_taddr[9:6];
    c1_pipe    <= d1_caddr[9:6];
    t3_pipe[0] <= d3_taddr[9:6];
    t3_pipe[1] <= t3_pipe[0];
    t3_pipe[2] <= t3_pipe[1];
    c3_pipe[0] <= d3_caddr[9:6];
    c3_pipe[1] <= c3_pipe[0];
    c3_pipe[2] <= c3_pipe[1];
  end

  assign d1_tdata = t1_pipe;
  assign d1_cdata = c1_pipe;
  assign d3_tdata = t3_pipe[2];
  assign d3_cdata = c3_pipe[2];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end else begin
      $display("ok   %s: %h", tag, obs);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int show, input int fs, input int sel, input int map,
                       input int chr, input int toff, input int coff);
    show_en      = 1'(show);
    frame_start  = 1'(fs);
    mem_select   = 2'(sel);
    address_map  = 5'(map);
    address_char = 8'(chr);
    tile_offset  = 6'(toff);
    char_offset  = 6'(coff);
  endtask

  task automatic idle();
    drive(0, 0, 3, 0, 0, 0, 0);
  endtask

  // One pixel through dut1: addresses checked at +1, RGB/show at +3.
  task automatic run_px(input string tag, input int show, input int fs, input int sel,
                        input int map, input int chr, input int toff, input int coff,
                        input logic [31:0] exp_taddr, input logic [31:0] exp_caddr,
                        input logic [31:0] exp_rgb, input logic [31:0] exp_show);
    drive(show, fs, sel, map, chr, toff, coff);
    step();
    check_val({tag, "_taddr"}, {21'h0, d1_taddr}, exp_taddr);
    check_val({tag, "_caddr"}, {18'h0, d1_caddr}, exp_caddr);
    idle();
    step();
    step();
    check_val({tag, "_rgb"}, {8'h0, d1_r, d1_g, d1_b}, exp_rgb);
    check_val({tag, "_show"}, {31'h0, d1_show}, exp_show);
  endtask

  task automatic pulse_frame();
    drive(0, 1, 3, 0, 0, 0, 0);
    step();
    idle();
  endtask

  function automatic logic [31:0] tb_rgb(input int idx);
    case (idx)
      1:       return 32'h002121FF;
      2:       return 32'h00FFB8AE;
      3:       return 32'h00FFFF00;
      4:       return 32'h00FF0000;
      default: return 32'h00000000;
    endcase
  endfunction

  initial begin
    int p, k, idx;
    rst = 1'b1;
    idle();

    // Reset held with random inputs.
    for (int i = 0; i < 3; i++) begin
      drive(int'($urandom_range(1)), int'($urandom_range(1)), int'($urandom_range(3)),
            int'($urandom_range(31)), int'($urandom_range(255)),
            int'($urandom_range(63)), int'($urandom_range(63)));
      step();
      check_val("rst_rgb", {8'h0, d1_r, d1_g, d1_b}, 32'h0);
      check_val("rst_show", {31'h0, d1_show}, 32'h0);
      check_val("rst_taddr", {21'h0, d1_taddr}, 32'h0);
      check_val("rst_caddr", {18'h0, d1_caddr}, 32'h0);
    end
    rst = 1'b0;
    idle();
    step();
    check_val("post_rst_rgb", {8'h0, d1_r, d1_g, d1_b}, 32'h0);
    check_val("post_rst_show", {31'h0, d1_show}, 32'h0);
    check_val("post_rst_taddr", {21'h0, d1_taddr}, 32'h0);
    step();
    step();

    run_px("map1", 1, 0, 0, 1, 0, 9, 0, 32'h049, 32'h0, 32'h002121FF, 32'h1);
    run_px("pacman", 1, 0, 1, 0, 3, 0, 0, 32'h0, 32'h0C0, 32'h00FFFF00, 32'h1);
    run_px("ghost", 1, 0, 2, 0, 4, 0, 0, 32'h0, 32'h100, 32'h00FF0000, 32'h1);
    run_px("sel_none", 1, 0, 3, 0, 3, 0, 0, 32'h0, 32'h0C0, 32'h0, 32'h1);
    run_px("blank", 0, 0, 0, 1, 0, 9, 0, 32'h049, 32'h0, 32'h0, 32'h0);

    // Reset one cycle after a visible pixel enters: it must not emerge.
    drive(1, 0, 0, 1, 0, 9, 0);
    step();
    rst = 1'b1;
    idle();
    step();
    rst = 1'b0;
    step();
    check_val("midrst_show", {31'h0, d1_show}, 32'h0);
    check_val("midrst_rgb", {8'h0, d1_r, d1_g, d1_b}, 32'h0);
    step();

    // Blink with BLINK_FRAMES=2: frame 0 starts at reset, later frames at pulses.
    run_px("blink_f0", 1, 0, 0, 2, 0, 0, 0, 32'h080, 32'h0, 32'h00FFB8AE, 32'h1);
    pulse_frame();
    run_px("blink_f1", 1, 0, 0, 2, 0, 0, 0, 32'h080, 32'h0, 32'h00FFB8AE, 32'h1);
    run_px("blink_f2_coinc", 1, 1, 0, 2, 0, 0, 0, 32'h080, 32'h0, 32'h00FFB8AE, 32'h1);
    run_px("blink_f2", 1, 0, 0, 2, 0, 0, 0, 32'h080, 32'h0, 32'h0, 32'h1);
    run_px("blink_f2_map1", 1, 0, 0, 1, 0, 0, 0, 32'h040, 32'h0, 32'h002121FF, 32'h1);
    pulse_frame();
    run_px("blink_f3", 1, 0, 0, 2, 0, 0, 0, 32'h080, 32'h0, 32'h0, 32'h1);
    pulse_frame();
    run_px("blink_f4", 1, 0, 0, 2, 0, 0, 0, 32'h080, 32'h0, 32'h00FFB8AE, 32'h1);

    // Full line through the ROM_LAT=3 instance: output for input cycle c
    // appears after the (c+5)th edge, i.e. loop iteration c+4.
    for (int i = 0; i < 6; i++) step();
    for (int c = 0; c < 645; c++) begin
      if (c < 640) begin
        k = c / 2;
        drive(1, 0, c % 2, (k % 2) ? 3 : 1, (k % 2) ? 4 : 3, c % 64, (c + 1) % 64);
      end else begin
        idle();
      end
      step();
      if (c >= 3) begin
        p = c - 4;
        if (p >= 0 && p < 640) begin
          k = p / 2;
          idx = (p % 2 == 0) ? ((k % 2) ? 3 : 1) : ((k % 2) ? 4 : 3);
          check_val($sformatf("line_show_%0d", p), {31'h0, d3_show}, 32'h1);
          check_val($sformatf("line_rgb_%0d", p), {8'h0, d3_r, d3_g, d3_b}, tb_rgb(idx));
        end else begin
          check_val($sformatf("line_edge_show_c%0d", c), {31'h0, d3_show}, 32'h0);
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
